ctl_seq: RTL and testbench
==========================

Name: ctl_seq

Overview:
Multi-cycle, parametrised control sequencer. It is the successor to the single-cycle combinational control decoder.
- Owns an instruction register and the FETCH/DECODE/EXEC/MEM/WB state machine.
- Runs ready/valid fetch and req/ack data-memory handshakes.
- Drives the datapath strobes (alu_op, alu_use_imm, reg_write_en, pc_en, branch select) one phase at a time.
- Sits between the instruction memory port and the existing ALU/regfile datapath.

Parameters:
INSTR_WIDTH, 16, instruction word width; opcode is the top OP_WIDTH bits.
OP_WIDTH, 4, opcode field width.
ALU_OP_WIDTH, 2, width of the alu_op output.

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
instr  in  INSTR_WIDTH  instruction word from fetch port
instr_valid  in  1  instr is valid this cycle
instr_ready  out  1  sequencer accepts instr this cycle
alu_zero  in  1  ALU zero flag, sampled in EXEC
mem_ack  in  1  data memory completed the access
mem_req  out  1  data memory access request
mem_we  out  1  1 = store, 0 = load (valid while mem_req)
ir  out  INSTR_WIDTH  latched instruction register
alu_op  out  ALU_OP_WIDTH  ALU operation (ADD/ADDI/LW/SW/BEQ=0, LSL=1)
alu_use_imm  out  1  ALU B operand = immediate
reg_write_en  out  1  register-file write strobe
pc_en  out  1  PC update strobe
pc_branch  out  1  PC takes branch/jump target on pc_en
jtype  out  1  IR holds a jump
halted  out  1  core halted
illegal  out  1  illegal-opcode trap (only with CTL_ILLEGAL_TRAP_EN)

Behaviour:
Reset
- rst_n low asynchronously forces: state = FETCH, ir = 0, branch-taken flag = 0.
- All strobes are 0 during reset: mem_req, mem_we, reg_write_en, pc_en, pc_branch, halted, illegal.
- instr_ready = 1 from the first cycle after rst_n rises.
- Reset mid-operation (any state, including an outstanding mem_req) aborts immediately; no strobe fires.

Opcodes
- Encodings come from defs.vh: OP_HALT, OP_ADD, OP_LSL, OP_ADDI, OP_BEQ, OP_LW, OP_SW, OP_J.

FETCH
- instr_ready = 1.
- On instr_valid & instr_ready: ir <= instr, next state DECODE.
- Otherwise stay in FETCH.

DECODE (1 cycle)
- OP_HALT -> HALTED.
- Illegal opcode -> see Optional Feature.
- Else -> EXEC.

EXEC (1 cycle)
- alu_op and alu_use_imm are valid (ADDI/LW/SW: use_imm = 1).
- BEQ latches taken = alu_zero.
- LW/SW -> MEM; all others -> WB.

MEM
- mem_req = 1 and mem_we = (op == SW), held until mem_ack.
- mem_ack in the first MEM cycle gives a 1-cycle MEM.
- Exit to WB on the cycle mem_ack = 1.
- mem_ack outside MEM is ignored.

WB (1 cycle)
- pc_en = 1.
- reg_write_en = 1 for ADD/LSL/ADDI/LW only.
- pc_branch = 1 for J, or for BEQ with taken.
- Next state FETCH.

HALTED
- halted = 1, instr_ready = 0, all other strobes 0.
- Sticky until rst_n.

Output rules
- alu_op and alu_use_imm decode from ir in every state (stable through MEM/WB).
- jtype = (ir opcode == OP_J) in all states.
- Strobes are decoded from the registered state only; no combinational path from instr to any output except instr_ready (which depends on state only).

Latency
- ALU/branch/jump instruction: 4 cycles (accept, DECODE, EXEC, WB).
- LW/SW: 5 + (ack wait) cycles.
- Back-to-back valid instructions are accepted every 4 cycles minimum.

Optional Feature:
Macro CTL_ILLEGAL_TRAP_EN.
- Defined: an opcode not in the list above sends DECODE -> TRAP. In TRAP, illegal = 1, halted = 1, instr_ready = 0; sticky until rst_n. No WB or pc_en occurs for the trapping instruction.
- Undefined: an illegal opcode executes as a NOP (DECODE -> EXEC -> WB with pc_en = 1, reg_write_en = 0, pc_branch = 0). The illegal port is tied 0.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high with instr_valid = 0 for 5 cycles -> instr_ready = 1; all strobes 0; ir = 0; state stays FETCH.
- ADD: {OP_ADD,12'h123} valid at cycle 0 -> ir = 16'h?123 at cycle 1; alu_op = 0 and alu_use_imm = 0 in EXEC; reg_write_en = 1 and pc_en = 1 only at cycle 3; instr_ready = 1 again at cycle 4.
- LW with delayed ack: {OP_LW,12'h005}, mem_ack raised 3 cycles after mem_req -> mem_req high exactly 4 cycles with mem_we = 0, alu_use_imm = 1; reg_write_en pulses once on the cycle after ack. Repeat with SW -> mem_we = 1, reg_write_en never asserted.
- BEQ: alu_zero = 1 in EXEC -> pc_branch = 1 with pc_en in WB; with alu_zero = 0 -> pc_en = 1, pc_branch = 0. OP_J -> jtype = 1 and pc_branch = 1.
- HALT and async reset: OP_HALT -> halted = 1 from cycle 2; further instr_valid ignored (instr_ready = 0). Separately, drop rst_n mid-MEM (mem_ack held 0) -> mem_req falls in the same cycle without a clock edge; after release, state is FETCH.
- Illegal opcode (run both builds): with CTL_ILLEGAL_TRAP_EN -> illegal = 1 and halted = 1 from cycle 2, no pc_en. Without it -> one pc_en at cycle 3, reg_write_en = 0, illegal = 0.

Source files
------------

// File: rtl/ctl_seq.sv
// ctl_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer.
// Owns the instruction register, runs the ready/valid fetch and req/ack
// data-memory handshakes, and strobes the datapath one phase at a time.
// Optional build macro: CTL_ILLEGAL_TRAP_EN (illegal opcode -> sticky TRAP).
// When it is undefined, illegal opcodes execute as NOPs.
module ctl_seq #(
  parameter int unsigned INSTR_WIDTH  = 16,
  parameter int unsigned OP_WIDTH     = 4,
  parameter int unsigned ALU_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INSTR_WIDTH-1:0]  instr,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic                    alu_zero,
  input  logic                    mem_ack,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [INSTR_WIDTH-1:0]  ir,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    alu_use_imm,
  output logic                    reg_write_en,
  output logic                    pc_en,
  output logic                    pc_branch,
  output logic                    jtype,
  output logic                    halted,
  output logic                    illegal
);

  localparam logic [OP_WIDTH-1:0] OP_HALT = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_LSL  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(7);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LSL = ALU_OP_WIDTH'(1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED,
    S_TRAP
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   taken;
  logic                   taken_nxt;
  logic [INSTR_WIDTH-1:0] ir_nxt;
  logic [OP_WIDTH-1:0]    op;
  logic [OP_WIDTH-1:0]    op_nxt;

  assign op     = ir[INSTR_WIDTH-1 -: OP_WIDTH];
  assign op_nxt = ir_nxt[INSTR_WIDTH-1 -: OP_WIDTH];

`ifdef CTL_ILLEGAL_TRAP_EN
  // Opcode is one of the defined encodings
  function automatic logic is_legal(input logic [OP_WIDTH-1:0] o);
    case (o)
      OP_HALT, OP_ADD, OP_LSL, OP_ADDI,
      OP_BEQ, OP_LW, OP_SW, OP_J: is_legal = 1'b1;
      default:                    is_legal = 1'b0;
    endcase
  endfunction
`endif

  // Next state, next instruction register and branch-taken flag
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    taken_nxt = taken;
    case (state)
      S_FETCH: begin
        if (instr_valid && instr_ready) begin
          ir_nxt    = instr;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_HALT) begin
          state_nxt = S_HALTED;
        end
`ifdef CTL_ILLEGAL_TRAP_EN
        else if (!is_legal(op)) begin
          state_nxt = S_TRAP;
        end
`endif
        else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_BEQ) taken_nxt = alu_zero;
        state_nxt = ((op == OP_LW) || (op == OP_SW)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_ack) state_nxt = S_WB;
      end
      S_WB:             state_nxt = S_FETCH;
      S_HALTED, S_TRAP: state_nxt = state;
      default:          state_nxt = S_FETCH;
    endcase
  end

  // State, IR and registered strobes decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      ir           <= '0;
      taken        <= 1'b0;
      instr_ready  <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      alu_op       <= ALU_ADD;
      alu_use_imm  <= 1'b0;
      reg_write_en <= 1'b0;
      pc_en        <= 1'b0;
      pc_branch    <= 1'b0;
      jtype        <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state        <= state_nxt;
      ir           <= ir_nxt;
      taken        <= taken_nxt;
      instr_ready  <= (state_nxt == S_FETCH);
      mem_req      <= (state_nxt == S_MEM);
      mem_we       <= (state_nxt == S_MEM) && (op_nxt == OP_SW);
      alu_op       <= (op_nxt == OP_LSL) ? ALU_LSL : ALU_ADD;
      alu_use_imm  <= (op_nxt == OP_ADDI) || (op_nxt == OP_LW) || (op_nxt == OP_SW);
      reg_write_en <= (state_nxt == S_WB) &&
                      ((op_nxt == OP_ADD) || (op_nxt == OP_LSL) ||
                       (op_nxt == OP_ADDI) || (op_nxt == OP_LW));
      pc_en        <= (state_nxt == S_WB);
      pc_branch    <= (state_nxt == S_WB) &&
                      ((op_nxt == OP_J) || ((op_nxt == OP_BEQ) && taken_nxt));
      jtype        <= (op_nxt == OP_J);
      halted       <= (state_nxt == S_HALTED) || (state_nxt == S_TRAP);
    end
  end

`ifdef CTL_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode trap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= (state_nxt == S_TRAP);
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ctl_seq.sv
// Self-checking bench for ctl_seq: per-instruction timeline model
// (accept, DECODE, EXEC, optional MEM wait, WB) compared every cycle.
module tb_ctl_seq;

  localparam logic [3:0] OP_HALT = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LSL  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_J    = 4'd7;

`ifdef CTL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_zero;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] ir;
  logic [1:0]  alu_op;
  logic        alu_use_imm;
  logic        reg_write_en;
  logic        pc_en;
  logic        pc_branch;
  logic        jtype;
  logic        halted;
  logic        illegal;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] prev_ir;

  always #5 clk = ~clk;

  ctl_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_zero     (alu_zero),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir           (ir),
    .alu_op       (alu_op),
    .alu_use_imm  (alu_use_imm),
    .reg_write_en (reg_write_en),
    .pc_en        (pc_en),
    .pc_branch    (pc_branch),
    .jtype        (jtype),
    .halted       (halted),
    .illegal      (illegal)
  );

  function automatic bit legal_op(input logic [3:0] o);
    return o <= OP_J;
  endfunction

  function automatic bit writes_reg(input logic [3:0] o);
    return (o == OP_ADD) || (o == OP_LSL) || (o == OP_ADDI) || (o == OP_LW);
  endfunction

  task automatic do_reset();
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    prev_ir = 16'h0000;
  endtask

  // One instruction: drive it, then compare every cycle against the timeline model
  task automatic run_instr(input logic [3:0] op, input logic [11:0] imm,
                           input bit zero, input int d);
    logic [15:0] iw;
    logic [15:0] exp_ir;
    logic [3:0]  eop;
    logic [9:0]  exp_s;
    logic [9:0]  got_s;
    logic [1:0]  exp_alu;
    bit          is_mem, trap, term, mreq, pc;
    int          wb, nk;
    iw     = {op, imm};
    is_mem = (op == OP_LW) || (op == OP_SW);
    trap   = TRAP_EN && !legal_op(op);
    term   = (op == OP_HALT) || trap;
    wb     = is_mem ? 4 + d : 3;
    nk     = term ? 6 : wb + 1;
    for (int k = 0; k < nk; k++) begin
      @(posedge clk);
      #1;
      instr_valid = (k == 0) ? 1'b1 : 1'($urandom);
      instr       = (k == 0) ? iw : 16'($urandom);
      alu_zero    = (k == 2) ? zero : 1'($urandom);
      if (is_mem && !term && k >= 3 && k <= 3 + d) mem_ack = (k == 3 + d);
      else                                        mem_ack = 1'($urandom);
      @(negedge clk);
      exp_ir  = (k == 0) ? prev_ir : iw;
      eop     = exp_ir[15:12];
      exp_alu = (eop == OP_LSL) ? 2'd1 : 2'd0;
      mreq    = is_mem && !term && k >= 3 && k <= 3 + d;
      pc      = !term && (k == wb);
      exp_s = {(k == 0), mreq, mreq && (op == OP_SW), pc && writes_reg(op), pc,
               pc && ((op == OP_J) || ((op == OP_BEQ) && zero)),
               term && k >= 2, trap && k >= 2, (eop == OP_J),
               (eop == OP_ADDI) || (eop == OP_LW) || (eop == OP_SW)};
      got_s = {instr_ready, mem_req, mem_we, reg_write_en, pc_en, pc_branch,
               halted, illegal, jtype, alu_use_imm};
      n_cmp++;
      if (ir !== exp_ir) begin
        n_err++;
        $display("FAIL ir op=%h k=%0d: got %h want %h", op, k, ir, exp_ir);
      end
      n_cmp++;
      if ({got_s, alu_op} !== {exp_s, exp_alu}) begin
        n_err++;
        $display("FAIL strobes op=%h k=%0d d=%0d [rdy req we rwe pc br hlt ill j imm alu]: got %b_%b want %b_%b",
                 op, k, d, got_s, alu_op, exp_s, exp_alu);
      end
    end
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    prev_ir     = iw;
  endtask

  task automatic test_reset();
    instr_valid = 1'b0;
    instr       = 16'h0000;
    alu_zero    = 1'b0;
    mem_ack     = 1'b0;
    rst_n       = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_we, reg_write_en, pc_en, pc_branch, halted, illegal, ir} !== 23'd0) begin
        n_err++;
        $display("FAIL reset_hold: got strobes %b ir %h want 0", 
                 {mem_req, mem_we, reg_write_en, pc_en, pc_branch, halted, illegal}, ir);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    prev_ir = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      mem_ack  = 1'($urandom);
      alu_zero = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({instr_ready, mem_req, mem_we, reg_write_en, pc_en, pc_branch, halted, illegal,
           jtype, alu_use_imm, alu_op, ir} !== {1'b1, 27'd0}) begin
        n_err++;
        $display("FAIL reset_idle k=%0d: got rdy=%b strobes=%b ir=%h want rdy=1 strobes=0 ir=0000",
                 k, instr_ready, {mem_req, mem_we, reg_write_en, pc_en, pc_branch, halted, illegal}, ir);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_alu();
    run_instr(OP_ADD, 12'h123, 1'($urandom), 0);
    run_instr(OP_LSL, 12'($urandom), 1'($urandom), 0);
    run_instr(OP_ADDI, 12'($urandom), 1'($urandom), 0);
  endtask

  task automatic test_mem();
    run_instr(OP_LW, 12'h005, 1'b0, 3);
    run_instr(OP_SW, 12'h005, 1'b0, 3);
    run_instr(OP_LW, 12'($urandom), 1'b1, 0);
    run_instr(OP_SW, 12'($urandom), 1'b1, 0);
  endtask

  task automatic test_branch();
    run_instr(OP_BEQ, 12'($urandom), 1'b1, 0);
    run_instr(OP_BEQ, 12'($urandom), 1'b0, 0);
    run_instr(OP_J, 12'($urandom), 1'($urandom), 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 7));
      run_instr(op, 12'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_halt();
    run_instr(OP_HALT, 12'($urandom), 1'b0, 0);
    do_reset();
    run_instr(OP_ADD, 12'($urandom), 1'b0, 0);
  endtask

  task automatic test_illegal();
    run_instr(4'hA, 12'($urandom), 1'b1, 0);
    if (TRAP_EN) do_reset();
    run_instr(4'hF, 12'($urandom), 1'b0, 0);
    if (TRAP_EN) do_reset();
    run_instr(OP_J, 12'($urandom), 1'b0, 0);
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr       = {OP_LW, 12'h005};
    mem_ack     = 1'b0;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL async_pre mem_req: got %b want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, reg_write_en, pc_en, pc_branch, halted, illegal} !== 7'd0) begin
      n_err++;
      $display("FAIL async_drop: got strobes %b want 0000000",
               {mem_req, mem_we, reg_write_en, pc_en, pc_branch, halted, illegal});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    prev_ir = 16'h0000;
    @(negedge clk);
    n_cmp++;
    if ({instr_ready, mem_req, pc_en, ir} !== {1'b1, 2'b00, 16'h0000}) begin
      n_err++;
      $display("FAIL async_release: got rdy=%b req=%b pc_en=%b ir=%h want 1 0 0 0000",
               instr_ready, mem_req, pc_en, ir);
    end
    run_instr(OP_ADD, 12'($urandom), 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_back_to_back();
    test_halt();
    test_illegal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
